// File: rtl/four_bit_2ch_rr_arbiter.sv
// Two-channel round-robin arbiter feeding a registered single-entry output stage.
// Optional per-channel accept counters are built when GRANT_COUNT_EN is defined.
module four_bit_2ch_rr_arbiter #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic [DATA_WIDTH-1:0]  In_0,
    input  logic                   In_0_Valid,
    output logic                   In_0_Ready,
    input  logic [DATA_WIDTH-1:0]  In_1,
    input  logic                   In_1_Valid,
    output logic                   In_1_Ready,
    output logic [DATA_WIDTH-1:0]  Out,
    output logic                   Select,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [COUNT_WIDTH-1:0] Grant_Cnt_0,
    output logic [COUNT_WIDTH-1:0] Grant_Cnt_1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   last_grant;
    logic   any_valid;
    logic   grant;
    logic   can_accept;
    logic   accept;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        any_valid = In_0_Valid | In_1_Valid;
        grant     = 1'b0;
        if (In_0_Valid && In_1_Valid) begin
            grant = ~last_grant;
        end else if (In_1_Valid) begin
            grant = 1'b1;
        end
    end

    // The output slot can take a word when empty or when it drains this same cycle.
    assign can_accept = (state == EMPTY) | Out_Ready;
    assign In_0_Ready = Reset_n & can_accept & any_valid & ~grant;
    assign In_1_Ready = Reset_n & can_accept & any_valid & grant;
    assign accept     = In_0_Ready | In_1_Ready;
    assign Out_Valid  = (state == FULL);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= EMPTY;
            Out        <= '0;
            Select     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (!accept && Out_Ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                Out        <= grant ? In_1 : In_0;
                Select     <= grant;
                last_grant <= grant;
            end
        end
    end

`ifdef GRANT_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_0;
    logic [COUNT_WIDTH-1:0] cnt_1;

    // Counters saturate at all-ones and only reset clears them.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (In_0_Ready && cnt_0 != '1) begin
                cnt_0 <= cnt_0 + COUNT_WIDTH'(1);
            end
            if (In_1_Ready && cnt_1 != '1) begin
                cnt_1 <= cnt_1 + COUNT_WIDTH'(1);
            end
        end
    end

    assign Grant_Cnt_0 = cnt_0;
    assign Grant_Cnt_1 = cnt_1;
`else
    assign Grant_Cnt_0 = '0;
    assign Grant_Cnt_1 = '0;
`endif

endmodule

// File: tb/tb_four_bit_2ch_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a rule-level model.
module tb_four_bit_2ch_rr_arbiter;

    localparam int DW      = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clock;
    logic          Reset_n;
    logic [DW-1:0] In_0;
    logic          In_0_Valid;
    logic          In_0_Ready;
    logic [DW-1:0] In_1;
    logic          In_1_Valid;
    logic          In_1_Ready;
    logic [DW-1:0] Out;
    logic          Select;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [CW-1:0] Grant_Cnt_0;
    logic [CW-1:0] Grant_Cnt_1;

    four_bit_2ch_rr_arbiter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .In_0       (In_0),
        .In_0_Valid (In_0_Valid),
        .In_0_Ready (In_0_Ready),
        .In_1       (In_1),
        .In_1_Valid (In_1_Valid),
        .In_1_Ready (In_1_Ready),
        .Out        (Out),
        .Select     (Select),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Grant_Cnt_0(Grant_Cnt_0),
        .Grant_Cnt_1(Grant_Cnt_1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: what the output slot holds and who was served last.
    logic          m_valid;
    logic [DW-1:0] m_out;
    logic          m_sel;
    logic          m_last;
    int            m_acc0;
    int            m_acc1;
    logic          last_acc0;
    logic          last_acc1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef GRANT_COUNT_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return (n > 0) ? 0 : 0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_sel   = 1'b0;
        m_last  = 1'b1;
        m_acc0  = 0;
        m_acc1  = 0;
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1,
                         input logic ordy, input string tag);
        logic room;
        logic winner;
        logic e_r0;
        logic e_r1;
        In_0       = d0;
        In_0_Valid = v0;
        In_1       = d1;
        In_1_Valid = v1;
        Out_Ready  = ordy;
        #1;
        room   = !m_valid || ordy;
        winner = (v0 && v1) ? !m_last : v1;
        e_r0   = room && v0 && (winner == 1'b0);
        e_r1   = room && v1 && (winner == 1'b1);
        check({tag, ".rdy0"}, In_0_Ready, e_r0);
        check({tag, ".rdy1"}, In_1_Ready, e_r1);
        last_acc0 = e_r0;
        last_acc1 = e_r1;
        if (e_r0 || e_r1) begin
            m_valid = 1'b1;
            m_out   = e_r1 ? d1 : d0;
            m_sel   = e_r1;
            m_last  = e_r1;
            if (e_r0) m_acc0++;
            if (e_r1) m_acc1++;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge Clock);
        #1;
        check({tag, ".vld"}, Out_Valid, m_valid);
        check({tag, ".out"}, Out, m_out);
        check({tag, ".sel"}, Select, m_sel);
        check({tag, ".cnt0"}, Grant_Cnt_0, exp_cnt(m_acc0));
        check({tag, ".cnt1"}, Grant_Cnt_1, exp_cnt(m_acc1));
    endtask

    // Asynchronous reset pulse placed mid-cycle, with both channels requesting.
    task automatic mid_reset(input string tag);
        #2;
        In_0_Valid = 1'b1;
        In_1_Valid = 1'b1;
        Out_Ready  = 1'b1;
        Reset_n    = 1'b0;
        #1;
        model_reset();
        check({tag, ".out"}, Out, 0);
        check({tag, ".sel"}, Select, 0);
        check({tag, ".vld"}, Out_Valid, 0);
        check({tag, ".rdy0"}, In_0_Ready, 0);
        check({tag, ".rdy1"}, In_1_Ready, 0);
        check({tag, ".cnt0"}, Grant_Cnt_0, 0);
        In_0_Valid = 1'b0;
        In_1_Valid = 1'b0;
        #2;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check({tag, ".idle_vld"}, Out_Valid, 0);
    endtask

    initial begin
        logic          v0;
        logic          v1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;

        Reset_n    = 1'b0;
        In_0       = '0;
        In_1       = '0;
        In_0_Valid = 1'b0;
        In_1_Valid = 1'b0;
        Out_Ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check("por.vld", Out_Valid, 0);
        check("por.out", Out, 0);

        // Reset asserted mid-cycle with a word held.
        cycle(1'b1, 4'hE, 1'b0, 4'h0, 1'b1, "pre1");
        mid_reset("rst1");

        // Single channel.
        cycle(1'b1, 4'hA, 1'b0, 4'h0, 1'b1, "single");
        check("single.hard_out", Out, 4'hA);

        // Fairness with both channels held valid.
        mid_reset("rst_fair");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'h3, 1'b1, 4'hC, 1'b1, "fair");
            check("fair.hard_sel", Select, i % 2);
        end

        // Backpressure then release to channel 1.
        cycle(1'b1, 4'h5, 1'b0, 4'h0, 1'b1, "bp_load");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'h0, 1'b1, 4'h9, 1'b0, "bp_hold");
        end
        check("bp.hold_out", Out, 4'h5);
        cycle(1'b0, 4'h0, 1'b1, 4'h9, 1'b1, "bp_rel");
        check("bp.rel_out", Out, 4'h9);
        check("bp.rel_sel", Select, 1);
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "full_idle");
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, "drain");
        cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, "empty_ordy");

        // Reset mid-transfer, then a tie goes to channel 0.
        cycle(1'b1, 4'h7, 1'b0, 4'h0, 1'b0, "mt_load");
        mid_reset("rst_mt");
        cycle(1'b1, 4'h2, 1'b1, 4'hB, 1'b1, "mt_tie");
        check("mt.tie_sel", Select, 0);

        // Counter saturation (or constant zero without the counter build).
        mid_reset("rst_cnt");
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 4'h0, 1'b1, "cnt0");
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 4'h0, 1'b1, DW'(i + 1), 1'b1, "cnt1");
        end
        check("cnt.final0", Grant_Cnt_0, exp_cnt(300));
        check("cnt.final1", Grant_Cnt_1, exp_cnt(2));

        // Random traffic obeying the source contract.
        mid_reset("rst_rand");
        v0 = 1'b0;
        v1 = 1'b0;
        d0 = '0;
        d1 = '0;
        last_acc0 = 1'b0;
        last_acc1 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!v0 || last_acc0) begin
                v0 = ($urandom_range(0, 3) != 0);
                d0 = DW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                v0 = 1'b0;
            end
            if (!v1 || last_acc1) begin
                v1 = ($urandom_range(0, 3) != 0);
                d1 = DW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                v1 = 1'b0;
            end
            cycle(v0, d0, v1, d1, ($urandom_range(0, 2) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
